memory_writer: RTL and testbench

- Stream-to-memory writer: the write-side counterpart of memory_reader.
- Accepts one Avalon-ST frame of packed complex samples (imag[31:16], real[15:0]) and writes it sample-by-sample into a word-addressed buffer (DFT input RAM / DMA write port) starting at address 0.
- Signals completion with a one-cycle done pulse and exposes a status field for DSP_SR.
- Sits between the DSP sink stream and the DFT core's buffer memory.

---
 rtl/memory_writer.sv | 169 ++++++++++++++++
 tb/tb_memory_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_writer.sv
// Stream-to-memory writer: lands one Avalon-ST frame of packed complex samples
// into a word-addressed buffer from address 0, then reports done/error/status.
module memory_writer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memory_writer_trigger,
    input  logic [ADDR_W:0]   memory_writer_number_of_points,
    input  logic [DATA_W-1:0] memory_writer_sink_data,
    input  logic              memory_writer_sink_valid,
    input  logic              memory_writer_sink_sop,
    input  logic              memory_writer_sink_eop,
    output logic              memory_writer_sink_ready,
    output logic [ADDR_W-1:0] memory_writer_writeaddress,
    output logic [DATA_W-1:0] memory_writer_writedata,
    output logic              memory_writer_write,
    input  logic              memory_writer_waitrequest,
    output logic              memory_writer_done,
    output logic              memory_writer_error,
    output logic [1:0]        memory_writer_status
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_WRITING = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE_N = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_r;
    logic [ADDR_W:0]     count_r;
    logic [ADDR_W:0]     n_r;
    logic                write_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic                done_r;
    logic                error_r;
    logic [1:0]          status_s;

    logic                stall_s;
    logic                sink_ready_s;
    logic                accept_s;
    logic                n_bad_s;
    logic [ADDR_W:0]     n_eff_s;
    logic                last_s;

    // Handshake and frame-length qualification derived from current registers
    always_comb begin
        stall_s      = write_r && memory_writer_waitrequest;
        sink_ready_s = 1'b0;
        if ((state_r == ST_ARMED) || (state_r == ST_WRITING)) begin
            sink_ready_s = !stall_s;
        end else begin
            sink_ready_s = 1'b0;
        end
        accept_s = memory_writer_sink_valid && sink_ready_s;
        n_bad_s  = (memory_writer_number_of_points == {(ADDR_W+1){1'b0}}) ||
                   (memory_writer_number_of_points > MAX_N);
        if (n_bad_s) begin
            n_eff_s = MAX_N;
        end else begin
            n_eff_s = memory_writer_number_of_points;
        end
        last_s = (count_r == (n_r - ONE_N));
    end

    // FLUSH is reported as WRITING since the frame is still landing in memory
    always_comb begin
        case (state_r)
            ST_IDLE:    status_s = 2'b00;
            ST_ARMED:   status_s = 2'b01;
            ST_WRITING: status_s = 2'b10;
            ST_FLUSH:   status_s = 2'b10;
            ST_DONE:    status_s = 2'b11;
            default:    status_s = 2'b00;
        endcase
    end

    // Frame FSM and write pipeline; a stalled write holds address/data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            count_r <= {(ADDR_W+1){1'b0}};
            n_r     <= {(ADDR_W+1){1'b0}};
            write_r <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (write_r && !memory_writer_waitrequest) begin
                write_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (memory_writer_trigger) begin
                        state_r <= ST_ARMED;
                        error_r <= 1'b0;
                    end
                end
                ST_ARMED, ST_WRITING: begin
                    if (accept_s) begin
                        if (memory_writer_sink_sop) begin
                            // New frame (or restart): relatch length, write at 0
                            n_r     <= n_eff_s;
                            write_r <= 1'b1;
                            addr_r  <= {ADDR_W{1'b0}};
                            data_r  <= memory_writer_sink_data;
                            count_r <= ONE_N;
                            if (n_bad_s || (state_r == ST_WRITING)) begin
                                error_r <= 1'b1;
                            end
                            if (n_eff_s == ONE_N) begin
                                state_r <= ST_FLUSH;
                            end else begin
                                state_r <= ST_WRITING;
                            end
                        end else if (state_r == ST_WRITING) begin
                            write_r <= 1'b1;
                            addr_r  <= count_r[ADDR_W-1:0];
                            data_r  <= memory_writer_sink_data;
                            count_r <= count_r + ONE_N;
                            if (last_s) begin
                                if (!memory_writer_sink_eop) begin
                                    error_r <= 1'b1;
                                end
                                state_r <= ST_FLUSH;
                            end else if (memory_writer_sink_eop) begin
                                error_r <= 1'b1;
                                state_r <= ST_FLUSH;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!write_r || !memory_writer_waitrequest) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (memory_writer_trigger) begin
                        state_r <= ST_ARMED;
                        error_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign memory_writer_sink_ready   = sink_ready_s;
    assign memory_writer_writeaddress = addr_r;
    assign memory_writer_writedata    = data_r;
    assign memory_writer_write        = write_r;
    assign memory_writer_done         = done_r;
    assign memory_writer_error        = error_r;
    assign memory_writer_status       = status_s;

endmodule

// File: tb/tb_memory_writer.sv
// Directed bench for memory_writer: frames, stalls, draining, error cases and
// mid-frame reset, with hand-computed expected write streams.
module tb_memory_writer;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trigger = 1'b0;
    logic [ADDR_W:0]   nop = '0;
    logic [DATA_W-1:0] sdata = '0;
    logic              svalid = 1'b0;
    logic              ssop = 1'b0;
    logic              seop = 1'b0;
    logic              waitreq = 1'b0;
    logic              sready;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic              done;
    logic              error;
    logic [1:0]        status;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wa_q[$];
    logic [31:0] wd_q[$];
    int wc_q[$];
    int done_cyc = 0;
    int done_cnt = 0;

    memory_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .memory_writer_trigger          (trigger),
        .memory_writer_number_of_points (nop),
        .memory_writer_sink_data        (sdata),
        .memory_writer_sink_valid       (svalid),
        .memory_writer_sink_sop         (ssop),
        .memory_writer_sink_eop         (seop),
        .memory_writer_sink_ready       (sready),
        .memory_writer_writeaddress     (waddr),
        .memory_writer_writedata        (wdata),
        .memory_writer_write            (write),
        .memory_writer_waitrequest      (waitreq),
        .memory_writer_done             (done),
        .memory_writer_error            (error),
        .memory_writer_status           (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side log: a write completes at the next edge when not stalled
    always @(negedge clk) begin
        if (rst_n && write && !waitreq) begin
            wa_q.push_back(int'(waddr));
            wd_q.push_back(wdata);
            wc_q.push_back(cyc);
        end
        if (rst_n && done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
    endtask

    // Offer one beat and hold it until accepted (ready sampled at edge+2)
    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        int t;
        sdata  = d;
        svalid = 1'b1;
        ssop   = s;
        seop   = e;
        #1;
        t = 0;
        while (!sready && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (t >= 100) chk("beat_ready", sready, 1);
        @(posedge clk);
        #1;
        svalid = 1'b0;
        ssop   = 1'b0;
        seop   = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            tick();
            t++;
        end
        chk("done_seen", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("status_done", status, 2'b11);
    endtask

    task automatic chk_write(input int i, input int a, input logic [31:0] d);
        if (i < wa_q.size()) begin
            chk("write_addr", wa_q[i], a);
            chk("write_data", wd_q[i], d);
        end else begin
            chk("write_missing", wa_q.size(), i + 1);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", sready, 0);
        chk("rst_write", write, 0);
        chk("rst_addr", waddr, 0);
        chk("rst_data", wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_status", status, 2'b00);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        tick();

        // Basic N=4 frame, no stalls
        clear_log();
        nop = 14'd4;
        pulse_trigger();
        chk("armed_status", status, 2'b01);
        chk("armed_ready", sready, 1);
        for (int i = 0; i < 4; i++) beat({16'(i + 1), 16'(i + 1)}, i == 0, i == 3);
        wait_done();
        chk("t1_error", error, 0);
        chk("t1_count", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_write(i, i, {16'(i + 1), 16'(i + 1)});
        if (wc_q.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("t1_b2b", wc_q[i], wc_q[i-1] + 1);
            chk("t1_done_latency", done_cyc, wc_q[3] + 1);
        end
        chk("t1_done_pulses", done_cnt, 1);

        // N=8 with a 3-cycle stall on the address-2 write
        clear_log();
        nop = 14'd8;
        pulse_trigger();
        fork
            begin
                for (int i = 0; i < 8; i++) beat(32'hA000_0000 + 32'(i), i == 0, i == 7);
            end
            begin
                int t;
                t = 0;
                while (!(write && waddr == 13'd2) && t < 100) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                chk("stall_seen", write && waddr == 13'd2, 1);
                waitreq = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    chk("stall_ready", sready, 0);
                    chk("stall_write", write, 1);
                    chk("stall_addr", waddr, 2);
                    chk("stall_data", wdata, 32'hA000_0002);
                    @(posedge clk);
                end
                #1;
                waitreq = 1'b0;
            end
        join
        wait_done();
        chk("t2_error", error, 0);
        chk("t2_count", wa_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_write(i, i, 32'hA000_0000 + 32'(i));

        // Drain non-SOP beats while armed, then a clean N=4 frame
        clear_log();
        nop = 14'd4;
        pulse_trigger();
        beat(32'h5555_0000, 1'b0, 1'b0);
        beat(32'h5555_0001, 1'b0, 1'b0);
        chk("drain_no_write", write, 0);
        chk("drain_log", wa_q.size(), 0);
        chk("drain_status", status, 2'b01);
        for (int i = 0; i < 4; i++) beat(32'hB000_0000 + 32'(i), i == 0, i == 3);
        wait_done();
        chk("t3_error", error, 0);
        chk("t3_count", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_write(i, i, 32'hB000_0000 + 32'(i));

        // Short frame: N=8, eop on the 5th beat
        clear_log();
        nop = 14'd8;
        pulse_trigger();
        for (int i = 0; i < 5; i++) beat(32'hC000_0000 + 32'(i), i == 0, i == 4);
        wait_done();
        chk("short_error", error, 1);
        chk("short_count", wa_q.size(), 5);
        for (int i = 0; i < 5; i++) chk_write(i, i, 32'hC000_0000 + 32'(i));
        pulse_trigger();
        chk("retrigger_error_clr", error, 0);
        chk("retrigger_status", status, 2'b01);

        // Restarting SOP on the 3rd beat, N=8 (already armed)
        clear_log();
        for (int i = 0; i < 10; i++) beat(32'hD000_0000 + 32'(i), (i == 0) || (i == 2), i == 9);
        wait_done();
        chk("resop_error", error, 1);
        chk("resop_count", wa_q.size(), 10);
        chk_write(0, 0, 32'hD000_0000);
        chk_write(1, 1, 32'hD000_0001);
        for (int i = 2; i < 10; i++) chk_write(i, i - 2, 32'hD000_0000 + 32'(i));

        // Mid-frame reset at address 5 (N=0 forces max length and error)
        clear_log();
        nop = 14'd0;
        pulse_trigger();
        for (int i = 0; i < 6; i++) beat(32'hE000_0000 + 32'(i), i == 0, 1'b0);
        chk("pre_rst_write", write, 1);
        chk("pre_rst_addr", waddr, 5);
        chk("n0_error", error, 1);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        clear_log();
        nop = 14'd4;
        pulse_trigger();
        for (int i = 0; i < 4; i++) beat(32'hF000_0000 + 32'(i), i == 0, i == 3);
        wait_done();
        chk("post_rst_error", error, 0);
        chk("post_rst_count", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_write(i, i, 32'hF000_0000 + 32'(i));

        // Single-sample frame
        clear_log();
        nop = 14'd1;
        pulse_trigger();
        beat(32'h1234_5678, 1'b1, 1'b1);
        wait_done();
        chk("n1_error", error, 0);
        chk("n1_count", wa_q.size(), 1);
        chk_write(0, 0, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
